gol_generation_engine: RTL and testbench

- Compute core of the Game of Life peripheral. Sits directly downstream of the AXI4-Lite slave register file.
- The register file writes the initial grid rows and issues start/generation-count commands. It reads back the evolved grid and the status.
- The grid is toroidal, ROWS x COLS cells, bit = 1 means alive. The engine advances the grid N generations, computing one full row per clock.

---
 rtl/gol_generation_engine.sv | 132 +++++++++++++
 tb/tb_gol_generation_engine.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gol_generation_engine.sv
// Game of Life generation engine: holds a toroidal ROWS x COLS grid and
// advances it a requested number of generations, one full row per clock.
module gol_generation_engine #(
    parameter int ROWS  = 8,
    parameter int COLS  = 32,
    parameter int GEN_W = 16
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    ld_valid,
    input  logic [$clog2(ROWS)-1:0] ld_addr,
    input  logic [COLS-1:0]         ld_data,
    input  logic                    start,
    input  logic [GEN_W-1:0]        gen_count,
    output logic                    busy,
    output logic                    done,
    output logic [GEN_W-1:0]        gens_run,
    input  logic [$clog2(ROWS)-1:0] rd_addr,
    output logic [COLS-1:0]         rd_data
);

    localparam int AW = $clog2(ROWS);
    localparam logic [AW-1:0] LAST = AW'(ROWS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SNAP = 2'd1;
    localparam logic [1:0] ROW  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]       state;
    logic [COLS-1:0]  grid [ROWS];
    logic [COLS-1:0]  row0_save;
    logic [COLS-1:0]  prev;
    logic [AW-1:0]    r;
    logic [AW-1:0]    r_next;
    logic [GEN_W-1:0] target;
    logic [GEN_W-1:0] gens_next;

    logic [COLS-1:0]  up;
    logic [COLS-1:0]  mid;
    logic [COLS-1:0]  down;
    logic [COLS-1:0]  new_row;

    // Column-rotated copies: x_l[c] = x[c-1], x_r[c] = x[c+1], wrapping around.
    logic [COLS-1:0]  up_l, up_r, mid_l, mid_r, down_l, down_r;

    function automatic logic cell_next(input logic [7:0] nb, input logic self);
        logic [3:0] cnt;
        cnt = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            cnt = cnt + {3'b000, nb[i]};
        end
        return (cnt == 4'd3) || ((cnt == 4'd2) && self);
    endfunction

    assign r_next    = r + 1'b1;
    assign gens_next = gens_run + 1'b1;

    // Row 0 is already overwritten when the last row is computed, so its
    // pre-generation copy comes from row0_save instead of the grid.
    assign up   = prev;
    assign mid  = grid[r];
    assign down = (r == LAST) ? row0_save : grid[r_next];

    assign up_l   = {up[COLS-2:0],   up[COLS-1]};
    assign up_r   = {up[0],          up[COLS-1:1]};
    assign mid_l  = {mid[COLS-2:0],  mid[COLS-1]};
    assign mid_r  = {mid[0],         mid[COLS-1:1]};
    assign down_l = {down[COLS-2:0], down[COLS-1]};
    assign down_r = {down[0],        down[COLS-1:1]};

    always_comb begin
        new_row = '0;
        for (int unsigned c = 0; c < COLS; c++) begin
            new_row[c] = cell_next({up_l[c], up[c], up_r[c],
                                    mid_l[c], mid_r[c],
                                    down_l[c], down[c], down_r[c]},
                                   mid[c]);
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state     <= IDLE;
            for (int unsigned i = 0; i < ROWS; i++) begin
                grid[i] <= '0;
            end
            row0_save <= '0;
            prev      <= '0;
            r         <= '0;
            target    <= '0;
            gens_run  <= '0;
            rd_data   <= '0;
        end else begin
            rd_data <= grid[rd_addr];
            case (state)
                IDLE: begin
                    if (ld_valid) begin
                        grid[ld_addr] <= ld_data;
                    end
                    if (start) begin
                        target   <= gen_count;
                        gens_run <= '0;
                        state    <= (gen_count == '0) ? DONE : SNAP;
                    end
                end
                SNAP: begin
                    row0_save <= grid[0];
                    prev      <= grid[LAST];
                    r         <= '0;
                    state     <= ROW;
                end
                ROW: begin
                    grid[r] <= new_row;
                    prev    <= mid;
                    r       <= r_next;
                    if (r == LAST) begin
                        gens_run <= gens_next;
                        state    <= (gens_next == target) ? DONE : SNAP;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gol_generation_engine.sv
// Self-checking bench for gol_generation_engine: directed patterns plus
// random grids compared against a cell-by-cell Game of Life model.
module tb_gol_generation_engine;

    localparam int ROWS  = 8;
    localparam int COLS  = 32;
    localparam int GEN_W = 16;

    logic              ACLK;
    logic              ARESET;
    logic              ld_valid;
    logic [2:0]        ld_addr;
    logic [COLS-1:0]   ld_data;
    logic              start;
    logic [GEN_W-1:0]  gen_count;
    logic              busy;
    logic              done;
    logic [GEN_W-1:0]  gens_run;
    logic [2:0]        rd_addr;
    logic [COLS-1:0]   rd_data;

    int errors = 0;
    int checks = 0;

    logic [31:0] init_g [ROWS];
    logic [31:0] grid_m [ROWS];
    logic [31:0] exp_g  [ROWS];

    gol_generation_engine #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .GEN_W (GEN_W)
    ) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .start     (start),
        .gen_count (gen_count),
        .busy      (busy),
        .done      (done),
        .gens_run  (gens_run),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    // One Game of Life generation on exp_g, computed directly from the rules.
    task automatic step_exp();
        logic [31:0] old [ROWS];
        int n;
        old = exp_g;
        for (int rr = 0; rr < ROWS; rr++) begin
            for (int c = 0; c < COLS; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr != 0 || dc != 0) begin
                            n += int'(old[(rr + dr + ROWS) % ROWS][(c + dc + COLS) % COLS]);
                        end
                    end
                end
                exp_g[rr][c] = (n == 3) || (n == 2 && old[rr][c]);
            end
        end
    endtask

    task automatic load_all();
        for (int a = 0; a < ROWS; a++) begin
            @(negedge ACLK);
            ld_valid = 1'b1;
            ld_addr  = 3'(a);
            ld_data  = init_g[a];
            grid_m[a] = init_g[a];
        end
        @(negedge ACLK);
        ld_valid = 1'b0;
    endtask

    task automatic verify_grid(input string tag);
        for (int a = 0; a < ROWS; a++) begin
            @(negedge ACLK);
            rd_addr = 3'(a);
            @(negedge ACLK);
            check(tag, rd_data, exp_g[a]);
        end
        grid_m = exp_g;
    endtask

    task automatic clear_init();
        for (int a = 0; a < ROWS; a++) begin
            init_g[a] = '0;
            exp_g[a]  = '0;
        end
    endtask

    task automatic run_gen(input int n, input bit disturb, input bit ld_en,
                           input int la, input logic [31:0] ld);
        int k;
        int limit;
        limit = n * (ROWS + 1) + 20;
        @(negedge ACLK);
        start     = 1'b1;
        gen_count = GEN_W'(n);
        ld_valid  = ld_en;
        ld_addr   = 3'(la);
        ld_data   = ld;
        @(posedge ACLK);
        #1;
        start    = 1'b0;
        ld_valid = 1'b0;
        @(negedge ACLK);
        k = 0;
        check("busy_on", busy, 1);
        while (done !== 1'b1 && k < limit) begin
            if (disturb && k == 3) begin
                start     = 1'b1;
                gen_count = 16'd3;
                ld_valid  = 1'b1;
                ld_addr   = 3'd0;
                ld_data   = 32'hFFFF_FFFF;
            end
            if (k == 4) begin
                start    = 1'b0;
                ld_valid = 1'b0;
            end
            @(negedge ACLK);
            k++;
        end
        start    = 1'b0;
        ld_valid = 1'b0;
        check("done_lat", k, n * (ROWS + 1));
        check("busy_in_done", busy, 1);
        @(negedge ACLK);
        check("done_pulse", done, 0);
        check("busy_off", busy, 0);
        if (n != 0) check("gens_run", gens_run, n);
        repeat (4) begin
            @(negedge ACLK);
            check("no_redone", done, 0);
        end
        verify_grid("grid");
    endtask

    task automatic directed(input int n, input bit disturb);
        load_all();
        run_gen(n, disturb, 1'b0, 0, '0);
    endtask

    initial begin
        ARESET    = 1'b1;
        ld_valid  = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
        start     = 1'b0;
        gen_count = '0;
        rd_addr   = '0;
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_gens", gens_run, 0);
        check("rst_rd", rd_data, 0);
        ARESET = 1'b0;

        // Horizontal blinker, one and two generations
        clear_init(); init_g[3] = 32'h70;
        exp_g[2] = 32'h20; exp_g[3] = 32'h20; exp_g[4] = 32'h20;
        directed(1, 1'b0);
        clear_init(); init_g[3] = 32'h70; exp_g[3] = 32'h70;
        directed(2, 1'b0);

        // Column wrap
        clear_init(); init_g[3] = 32'h8000_0003;
        exp_g[2] = 32'h1; exp_g[3] = 32'h1; exp_g[4] = 32'h1;
        directed(1, 1'b0);

        // Row wrap
        clear_init(); init_g[7] = 32'h20; init_g[0] = 32'h20; init_g[1] = 32'h20;
        exp_g[0] = 32'h70;
        directed(1, 1'b0);

        // Still life over five generations, then a zero-generation run
        clear_init(); init_g[4] = 32'h180; init_g[5] = 32'h180;
        exp_g[4] = 32'h180; exp_g[5] = 32'h180;
        directed(5, 1'b0);
        run_gen(0, 1'b0, 1'b0, 0, '0);

        // Start and load while busy are ignored
        clear_init(); init_g[3] = 32'h70;
        exp_g[2] = 32'h20; exp_g[3] = 32'h20; exp_g[4] = 32'h20;
        directed(1, 1'b1);

        // Reset in the middle of a run
        clear_init(); init_g[3] = 32'h70;
        load_all();
        @(negedge ACLK);
        start = 1'b1; gen_count = 16'd3;
        @(posedge ACLK); #1 start = 1'b0;
        repeat (4) @(negedge ACLK);
        ARESET = 1'b1;
        @(negedge ACLK);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_gens", gens_run, 0);
        check("midrst_rd", rd_data, 0);
        ARESET = 1'b0;
        verify_grid("midrst_grid");
        exp_g[2] = 32'h20; exp_g[3] = 32'h20; exp_g[4] = 32'h20;
        directed(1, 1'b0);

        // Random grids, some with a load in the same cycle as start
        for (int it = 0; it < 8; it++) begin
            int n;
            bit le;
            int la;
            logic [31:0] ld;
            for (int a = 0; a < ROWS; a++) init_g[a] = $urandom & $urandom;
            n  = $urandom_range(0, 3);
            le = 1'($urandom_range(0, 1));
            la = $urandom_range(0, ROWS - 1);
            ld = $urandom;
            load_all();
            if (le) grid_m[la] = ld;
            exp_g = grid_m;
            for (int g = 0; g < n; g++) step_exp();
            run_gen(n, 1'b0, le, la, ld);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

endmodule
